// File: rtl/add8_err_pkg.sv
// Shared types and width helpers for the approximate-adder error meter.
// Widths are derived from the operand width W.
package add8_err_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int W_DEF = 8;

  function automatic int sae_w(input int w);
    return 3 * w + 1;
  endfunction

  function automatic int sse_w(input int w);
    return 4 * w + 2;
  endfunction

  function automatic int hd_w(input int w);
    return 2 * w + 4;
  endfunction

  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int pop_w(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/add8_err_stage.sv
// Combinational per-pair error terms: mismatch flag, |err|,
// err^2 and Hamming distance against the exact sum.
module add8_err_stage
  import add8_err_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int PW = pop_w(W)
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  input  logic [W:0]     i_res,
  output logic           o_err,
  output logic [W:0]     o_abs,
  output logic [2*W+1:0] o_sq,
  output logic [PW-1:0]  o_pop
);

  logic [W:0]     w_exact;
  logic [W:0]     w_x;
  logic [2*W+1:0] w_abs_ext;

  assign w_exact = {1'b0, i_a} + {1'b0, i_b};
  assign o_err   = (i_res != w_exact);

  assign o_abs = (i_res >= w_exact) ?
                 (i_res - w_exact) :
                 (w_exact - i_res);

  assign w_abs_ext = {{(W+1){1'b0}}, o_abs};
  assign o_sq      = w_abs_ext * w_abs_ext;
  assign w_x       = i_res ^ w_exact;

  // Popcount of the differing result bits
  always_comb begin
    o_pop = '0;
    for (int i = 0; i <= W; i++) begin
      o_pop = o_pop + PW'(w_x[i]);
    end
  end

endmodule

// File: rtl/add8_err_meter.sv
// Sweeps all operand pairs through an external adder and
// accumulates EP/MAE/MSE/WCE/HD error metrics.
module add8_err_meter
  import add8_err_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int SAE_W = sae_w(W),
  parameter int SSE_W = sse_w(W),
  parameter int HD_W  = hd_w(W),
  parameter int CNT_W = cnt_w(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  output logic             op_vld,
  input  logic [W:0]       res_in,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SAE_W-1:0] sae,
  output logic [SSE_W-1:0] sse,
  output logic [W:0]       wce,
  output logic [W-1:0]     wce_a,
  output logic [W-1:0]     wce_b,
  output logic [HD_W-1:0]  hd_sum
);

  localparam int PW = pop_w(W);
  localparam int NW = 2 * W;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_clr;
  logic   w_last;

  logic [NW-1:0] r_cnt;

  logic           w_err;
  logic [W:0]     w_abs;
  logic [2*W+1:0] w_sq;
  logic [PW-1:0]  w_pop;

  logic           r_s1_vld;
  logic           r_s1_err;
  logic [W:0]     r_s1_abs;
  logic [2*W+1:0] r_s1_sq;
  logic [PW-1:0]  r_s1_pop;
  logic [W-1:0]   r_s1_a;
  logic [W-1:0]   r_s1_b;

  logic [CNT_W-1:0] r_err_cnt;
  logic [SAE_W-1:0] r_sae;
  logic [SSE_W-1:0] r_sse;
  logic [W:0]       r_wce;
  logic [W-1:0]     r_wce_a;
  logic [W-1:0]     r_wce_b;
  logic [HD_W-1:0]  r_hd;

  assign w_last = (r_cnt == {NW{1'b1}});

  // Next-state logic; a start from IDLE/DONE clears the metrics
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_SWEEP;
          w_clr       = 1'b1;
        end
      end
      ST_SWEEP: begin
        if (w_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Pair counter; wraps after the last pair and is left idle
  always_ff @(posedge clk) begin
    if (!rst_n || w_clr)          r_cnt <= '0;
    else if (r_state == ST_SWEEP) r_cnt <= r_cnt + 1'b1;
  end

  assign op_a   = r_cnt[W-1:0];
  assign op_b   = r_cnt[NW-1:W];
  assign op_vld = (r_state == ST_SWEEP);
  assign busy   = (r_state == ST_SWEEP) ||
                  (r_state == ST_DRAIN);
  assign done   = (r_state == ST_DONE);

  add8_err_stage #(
    .W  (W),
    .PW (PW)
  ) u_stage (
    .i_a   (op_a),
    .i_b   (op_b),
    .i_res (res_in),
    .o_err (w_err),
    .o_abs (w_abs),
    .o_sq  (w_sq),
    .o_pop (w_pop)
  );

  // S1: capture per-pair error terms alongside the operands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_err <= 1'b0;
      r_s1_abs <= '0;
      r_s1_sq  <= '0;
      r_s1_pop <= '0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
    end else begin
      r_s1_vld <= op_vld;
      r_s1_err <= w_err;
      r_s1_abs <= w_abs;
      r_s1_sq  <= w_sq;
      r_s1_pop <= w_pop;
      r_s1_a   <= op_a;
      r_s1_b   <= op_b;
    end
  end

  // S2: accumulate metrics; strict > keeps the earliest worst pair
  always_ff @(posedge clk) begin
    if (!rst_n || w_clr) begin
      r_err_cnt <= '0;
      r_sae     <= '0;
      r_sse     <= '0;
      r_wce     <= '0;
      r_wce_a   <= '0;
      r_wce_b   <= '0;
      r_hd      <= '0;
    end else if (r_s1_vld) begin
      r_err_cnt <= r_err_cnt + CNT_W'(r_s1_err);
      r_sae     <= r_sae + SAE_W'(r_s1_abs);
      r_sse     <= r_sse + SSE_W'(r_s1_sq);
      r_hd      <= r_hd + HD_W'(r_s1_pop);
      if (r_s1_abs > r_wce) begin
        r_wce   <= r_s1_abs;
        r_wce_a <= r_s1_a;
        r_wce_b <= r_s1_b;
      end
    end
  end

  assign err_cnt = r_err_cnt;
  assign sae     = r_sae;
  assign sse     = r_sse;
  assign wce     = r_wce;
  assign wce_a   = r_wce_a;
  assign wce_b   = r_wce_b;
  assign hd_sum  = r_hd;

endmodule

// File: tb/tb_add8_err_meter.sv
// Bench for add8_err_meter: W=2 and W=8 instances driving
// model adders, results checked by a done-triggered scoreboard.
module tb_add8_err_meter;

  typedef struct {
    longint cnt, sae, sse, wce, wa, wb, hd, cyc, vld;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  longint tb_cyc = 0;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  // W=2 instance signals
  logic       rst2, start2, busy2, done2, vld2;
  logic [1:0] a2, b2, wa2, wb2;
  logic [2:0] res2, wce2;
  logic [4:0] ec2;
  logic [6:0] sae2;
  logic [9:0] sse2;
  logic [7:0] hd2;
  int         mode2;

  // W=8 instance signals
  logic        rst8, start8, busy8, done8, vld8;
  logic [7:0]  a8, b8, wa8, wb8;
  logic [8:0]  res8, wce8;
  logic [16:0] ec8;
  logic [24:0] sae8;
  logic [33:0] sse8;
  logic [19:0] hd8;
  int          mode8;

  longint mark2, mark8;
  exp_t   q2[$];
  exp_t   q8[$];
  logic [3:0] pq[$];

  function automatic logic [8:0] add8m(
    input logic [7:0] a, input logic [7:0] b, input int m);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (m == 1)      s = s & 9'h1FE;
    else if (m == 2) s = '0;
    return s;
  endfunction

  function automatic logic [2:0] add2m(
    input logic [1:0] a, input logic [1:0] b, input int m);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (m == 1)      s = s & 3'b110;
    else if (m == 2) s = '0;
    return s;
  endfunction

  always_comb res2 = add2m(a2, b2, mode2);
  always_comb res8 = add8m(a8, b8, mode8);

  add8_err_meter #(.W(2)) u_dut2 (
    .clk(clk), .rst_n(rst2), .start(start2),
    .busy(busy2), .done(done2),
    .op_a(a2), .op_b(b2), .op_vld(vld2),
    .res_in(res2), .err_cnt(ec2), .sae(sae2),
    .sse(sse2), .wce(wce2), .wce_a(wa2),
    .wce_b(wb2), .hd_sum(hd2)
  );

  add8_err_meter #(.W(8)) u_dut8 (
    .clk(clk), .rst_n(rst8), .start(start8),
    .busy(busy8), .done(done8),
    .op_a(a8), .op_b(b8), .op_vld(vld8),
    .res_in(res8), .err_cnt(ec8), .sae(sae8),
    .sse(sse8), .wce(wce8), .wce_a(wa8),
    .wce_b(wb8), .hd_sum(hd8)
  );

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d",
                  nm, act, exp);
  endtask

  task automatic cmp_res(
    input string t, input exp_t e,
    input longint c, input longint s, input longint q,
    input longint w, input longint a, input longint b,
    input longint h, input longint cy, input longint v);
    chk({t, "_err_cnt"}, c, e.cnt);
    chk({t, "_sae"}, s, e.sae);
    chk({t, "_sse"}, q, e.sse);
    chk({t, "_wce"}, w, e.wce);
    chk({t, "_wce_a"}, a, e.wa);
    chk({t, "_wce_b"}, b, e.wb);
    chk({t, "_hd_sum"}, h, e.hd);
    chk({t, "_done_cycle"}, cy, e.cyc);
    chk({t, "_op_vld_cycles"}, v, e.vld);
  endtask

  // Monitor for the W=2 instance: results on done rise, pair order
  int   vc2 = 0;
  logic pd2 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] p;
    if (done2 && !pd2) begin
      if (q2.size() == 0) begin
        n_chk++;
        $display("FAIL w2_unexpected_done: no pending sweep");
      end else begin
        e = q2.pop_front();
        cmp_res("w2", e, longint'(ec2), longint'(sae2),
                longint'(sse2), longint'(wce2),
                longint'(wa2), longint'(wb2),
                longint'(hd2), tb_cyc - mark2,
                longint'(vc2));
      end
      vc2 = 0;
    end else if (!busy2 && !done2) begin
      vc2 = 0;
    end else if (vld2) begin
      vc2++;
    end
    pd2 = done2;
    if (vld2 && pq.size() > 0) begin
      p = pq.pop_front();
      chk("w2_pair_ba", longint'({b2, a2}), longint'(p));
    end
  end

  // Monitor for the W=8 instance
  int   vc8 = 0;
  logic pd8 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done8 && !pd8) begin
      if (q8.size() == 0) begin
        n_chk++;
        $display("FAIL w8_unexpected_done: no pending sweep");
      end else begin
        e = q8.pop_front();
        cmp_res("w8", e, longint'(ec8), longint'(sae8),
                longint'(sse8), longint'(wce8),
                longint'(wa8), longint'(wb8),
                longint'(hd8), tb_cyc - mark8,
                longint'(vc8));
      end
      vc8 = 0;
    end else if (!busy8 && !done8) begin
      vc8 = 0;
    end else if (vld8) begin
      vc8++;
    end
    pd8 = done8;
  end

  task automatic go2();
    start2 = 1'b1;
    mark2  = tb_cyc;
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic go8();
    start8 = 1'b1;
    mark8  = tb_cyc;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait2(input int lim);
    int k = 0;
    while (!done2 && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (!done2) begin
      n_chk++;
      $display("FAIL w2_timeout: done=0 after %0d cycles", k);
    end
    @(negedge clk);
  endtask

  task automatic wait8(input int lim);
    int k = 0;
    while (!done8 && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (!done8) begin
      n_chk++;
      $display("FAIL w8_timeout: done=0 after %0d cycles", k);
    end
    @(negedge clk);
  endtask

  localparam exp_t E2_EXACT = '{0, 0, 0, 0, 0, 0, 0, 18, 16};
  localparam exp_t E2_LSB   = '{8, 8, 8, 1, 1, 0, 8, 18, 16};
  localparam exp_t E2_ZERO  = '{15, 48, 184, 6, 3, 3, 22, 18, 16};
  localparam exp_t E8_LSB   = '{32768, 32768, 32768, 1, 1, 0,
                                32768, 65538, 65536};

  initial begin
    rst2 = 1'b0; rst8 = 1'b0;
    start2 = 1'b0; start8 = 1'b0;
    mode2 = 0; mode8 = 0;
    mark2 = 0; mark8 = 0;
    repeat (3) @(negedge clk);

    chk("rst_done2", longint'(done2), 0);
    chk("rst_busy2", longint'(busy2), 0);
    chk("rst_vld8", longint'(vld8), 0);
    chk("rst_sse8", longint'(sse8), 0);
    chk("rst_opa8", longint'(a8), 0);
    rst2 = 1'b1; rst8 = 1'b1;
    @(negedge clk);

    // Exact adder, pair order check
    for (int i = 0; i < 16; i++) pq.push_back(4'(i));
    q2.push_back(E2_EXACT);
    go2();
    wait2(40);

    // LSB-dropped adder, restart from DONE
    mode2 = 1;
    q2.push_back(E2_LSB);
    go2();
    wait2(40);

    // Stuck-zero adder with an ignored mid-sweep start
    mode2 = 2;
    q2.push_back(E2_ZERO);
    go2();
    repeat (3) @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    wait2(40);

    // Start while done: metrics clear on the next edge
    mode2 = 0;
    q2.push_back(E2_EXACT);
    go2();
    chk("restart_done", longint'(done2), 0);
    chk("restart_busy", longint'(busy2), 1);
    chk("restart_err_cnt", longint'(ec2), 0);
    chk("restart_sse", longint'(sse2), 0);
    wait2(40);

    // Reset in the middle of a stuck-zero sweep
    mode2 = 2;
    go2();
    repeat (4) @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk);
    rst2 = 1'b1;
    chk("midrst_busy", longint'(busy2), 0);
    chk("midrst_vld", longint'(vld2), 0);
    chk("midrst_opa", longint'(a2), 0);
    chk("midrst_err_cnt", longint'(ec2), 0);
    chk("midrst_sae", longint'(sae2), 0);
    chk("midrst_hd", longint'(hd2), 0);
    @(negedge clk);
    mode2 = 0;
    q2.push_back(E2_EXACT);
    go2();
    wait2(40);

    // Full W=8 sweep with the LSB-dropped adder
    mode8 = 1;
    q8.push_back(E8_LSB);
    go8();
    wait8(70000);

    chk("w2_results_left", longint'(q2.size()), 0);
    chk("w8_results_left", longint'(q8.size()), 0);
    chk("w2_pairs_left", longint'(pq.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
